// File: rtl/tiny16_memctl.sv
// tiny16_memctl: bus controller between the tiny16 CPU and its ROM, RAM and
// I/O targets. Decodes the CPU address, inserts per-region wait states by
// holding ready low, drives the selected target and returns read data.
//
// Regions: 0x0000-0x7FFF ROM, 0x8000-0xFEFF RAM, 0xFF00-0xFFFF I/O.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   address, cpu_wdata    CPU address and write data
//   cpu_rdata             read data returned to the CPU (held between reads)
//   rd, wr                active-low CPU strobes
//   ready                 high = access complete / idle, low = CPU stalls
//   bus_error             one-cycle pulse on an illegal access or I/O timeout
//   rom_addr, rom_data    ROM word address / read data
//   ram_addr, ram_wdata,
//   ram_rdata, ram_we     RAM port, ram_we is a one-cycle write enable
//   io_addr, io_wdata,
//   io_rdata, io_rd,
//   io_wr, io_ack         I/O port, strobes held until ack or timeout
module tiny16_memctl #(
  parameter int unsigned ROM_WAIT   = 1,
  parameter int unsigned RAM_WAIT   = 0,
  parameter int unsigned IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  input  logic        rd,
  input  logic        wr,
  output logic        ready,
  output logic        bus_error,
  output logic [14:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [14:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        ram_we,
  output logic [7:0]  io_addr,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  output logic        io_rd,
  output logic        io_wr,
  input  logic        io_ack
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_IO, ST_DONE} state_t;

  localparam logic [3:0] ROM_W   = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W   = 4'(RAM_WAIT);
  localparam logic [7:0] IO_LAST = 8'(IO_TIMEOUT - 1);

  state_t      state;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_rd;
  logic        lat_wr;
  logic [3:0]  wcnt;
  logic [7:0]  tcnt;

  logic        rd_req;
  logic        wr_req;
  logic        both;
  logic        in_rom;
  logic        in_io;
  logic        in_ram;
  logic        changed;
  logic        start;
  logic [3:0]  start_wait;
  logic        start_quick;
  logic        start_slow;
  logic        wait_done;
  logic [15:0] addr_mux;
  logic [15:0] wdata_mux;

  always_comb begin
    rd_req  = !rd && wr;
    wr_req  = rd && !wr;
    both    = !rd && !wr;
    in_rom  = !address[15];
    in_io   = &address[15:8];
    in_ram  = !in_rom && !in_io;
    changed = {address, rd, wr} != {lat_addr, lat_rd, lat_wr};

    // A new access is accepted from IDLE, or straight out of DONE when the
    // CPU has moved on to a different address or direction.
    start = !reset && (!rd || !wr) &&
            ((state == ST_IDLE) || ((state == ST_DONE) && changed));

    start_wait = '0;
    if (in_rom)
      start_wait = ROM_W;
    else if (in_ram)
      start_wait = RAM_W;

    // The request cycle itself counts as the first wait cycle, so waits of
    // 0 and 1 both complete at the request edge; only ready differs.
    start_quick = start && !both && !in_io && (start_wait <= 4'd1);
    start_slow  = start && !both && (in_io || (start_wait != 4'd0));
    wait_done   = (state == ST_WAIT) && (wcnt == 4'd1);

    ready = !((state == ST_WAIT) || (state == ST_IO) || start_slow);

    // Only RAM ever enters WAIT with a write, so bit 15 selects RAM there.
    ram_we = !reset &&
             ((start_quick && in_ram && wr_req) ||
              (wait_done && lat_addr[15] && !lat_wr));

    // Targets see the live address in the request cycle so zero-wait reads
    // return data at that edge; afterwards the latched copy is held.
    addr_mux  = start ? address : lat_addr;
    wdata_mux = start ? cpu_wdata : lat_wdata;
    rom_addr  = addr_mux[14:0];
    ram_addr  = addr_mux[14:0];
    io_addr   = addr_mux[7:0];
    ram_wdata = wdata_mux;
    io_wdata  = wdata_mux;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rd    <= 1'b1;
      lat_wr    <= 1'b1;
      wcnt      <= '0;
      tcnt      <= '0;
      cpu_rdata <= '0;
      bus_error <= 1'b0;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      if (start) begin
        lat_addr  <= address;
        lat_wdata <= cpu_wdata;
        lat_rd    <= rd;
        lat_wr    <= wr;
        io_rd     <= 1'b0;
        io_wr     <= 1'b0;
        wcnt      <= '0;
        tcnt      <= '0;
        if (both) begin
          bus_error <= 1'b1;
          state     <= ST_DONE;
        end else if (in_io) begin
          io_rd <= rd_req;
          io_wr <= wr_req;
          state <= ST_IO;
        end else if (start_wait <= 4'd1) begin
          if (rd_req)
            cpu_rdata <= in_rom ? rom_data : ram_rdata;
          if (in_rom && wr_req)
            bus_error <= 1'b1;
          state <= ST_DONE;
        end else begin
          wcnt  <= start_wait - 4'd1;
          state <= ST_WAIT;
        end
      end else begin
        case (state)
          ST_WAIT: begin
            if (wcnt == 4'd1) begin
              if (!lat_rd)
                cpu_rdata <= lat_addr[15] ? ram_rdata : rom_data;
              if (!lat_addr[15] && !lat_wr)
                bus_error <= 1'b1;
              wcnt  <= '0;
              state <= ST_DONE;
            end else begin
              wcnt <= wcnt - 4'd1;
            end
          end
          ST_IO: begin
            // Ack is checked first so it wins over a simultaneous timeout.
            if (io_ack) begin
              if (io_rd)
                cpu_rdata <= io_rdata;
              io_rd <= 1'b0;
              io_wr <= 1'b0;
              state <= ST_DONE;
            end else if (tcnt == IO_LAST) begin
              bus_error <= 1'b1;
              cpu_rdata <= 16'hFFFF;
              io_rd     <= 1'b0;
              io_wr     <= 1'b0;
              state     <= ST_DONE;
            end else begin
              tcnt <= tcnt + 8'd1;
            end
          end
          ST_DONE: begin
            if (rd && wr)
              state <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tiny16_memctl.sv
// Directed bench for tiny16_memctl: a default-parameter instance driven by a
// cycle table, plus a second instance (RAM_WAIT=3, IO_TIMEOUT=4) for the
// multi-cycle wait, reset-abort and I/O ack corner cases.
module tb_tiny16_memctl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = '0;
  logic [15:0] cpu_wdata = '0;
  logic        rd = 1'b1;
  logic        wr = 1'b1;
  logic [15:0] rom_data = 16'h5A5A;
  logic [15:0] io_rdata = '0;
  logic        io_ack = 1'b0;
  logic [15:0] ram_rdata3 = '0;

  logic [15:0] rdata1, ram_wdata1, ram_rdata1, io_wdata1;
  logic [14:0] rom_addr1, ram_addr1;
  logic [7:0]  io_addr1;
  logic        ready1, berr1, ram_we1, io_rd1, io_wr1;

  logic [15:0] rdata3, ram_wdata3, io_wdata3;
  logic [14:0] rom_addr3, ram_addr3;
  logic [7:0]  io_addr3;
  logic        ready3, berr3, ram_we3, io_rd3, io_wr3;

  int checks = 0;
  int errors = 0;
  int we3_cnt = 0;

  always #5 clk = ~clk;

  tiny16_memctl u_dut (
    .clk(clk), .reset(reset), .address(address), .cpu_wdata(cpu_wdata),
    .cpu_rdata(rdata1), .rd(rd), .wr(wr), .ready(ready1), .bus_error(berr1),
    .rom_addr(rom_addr1), .rom_data(rom_data), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .ram_we(ram_we1),
    .io_addr(io_addr1), .io_wdata(io_wdata1), .io_rdata(io_rdata),
    .io_rd(io_rd1), .io_wr(io_wr1), .io_ack(io_ack)
  );

  tiny16_memctl #(.ROM_WAIT(1), .RAM_WAIT(3), .IO_TIMEOUT(4)) u_dut3 (
    .clk(clk), .reset(reset), .address(address), .cpu_wdata(cpu_wdata),
    .cpu_rdata(rdata3), .rd(rd), .wr(wr), .ready(ready3), .bus_error(berr3),
    .rom_addr(rom_addr3), .rom_data(rom_data), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .ram_we(ram_we3),
    .io_addr(io_addr3), .io_wdata(io_wdata3), .io_rdata(io_rdata),
    .io_rd(io_rd3), .io_wr(io_wr3), .io_ack(io_ack)
  );

  // Small combinational-read RAM behind the default instance.
  logic [15:0] mem [16];
  assign ram_rdata1 = mem[ram_addr1[3:0]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (ram_we1) begin
      mem[ram_addr1[3:0]] <= ram_wdata1;
    end
  end

  always @(posedge clk) if (ram_we3) we3_cnt <= we3_cnt + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] wd;
    logic        r;
    logic        w;
    logic        ak;
    logic [15:0] id;
    logic        erdy;
    logic        eber;
    logic [15:0] erd;
    logic        ewe;
    logic        eiord;
    logic [14:0] era;
    logic [7:0]  eio;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [15:0] a, logic [15:0] wd, logic r, logic w,
                              logic ak, logic [15:0] id, logic erdy, logic eber,
                              logic [15:0] erd, logic ewe, logic eiord,
                              logic [14:0] era, logic [7:0] eio);
    vec_t v;
    v.a = a; v.wd = wd; v.r = r; v.w = w; v.ak = ak; v.id = id;
    v.erdy = erdy; v.eber = eber; v.erd = erd; v.ewe = ewe; v.eiord = eiord;
    v.era = era; v.eio = eio;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, settle, then sample.
  task automatic cyc(input logic [15:0] a, input logic [15:0] wd, input logic r,
                     input logic w, input logic ak, input logic [15:0] id,
                     input logic rs);
    @(negedge clk);
    address = a; cpu_wdata = wd; rd = r; wr = w; io_ack = ak; io_rdata = id;
    reset = rs;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        addr      wdata     rd wr ak iodata    rdy be rdata     we iord raddr      ioaddr
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 15'h0000, 8'h00));
    tbl.push_back(mk(16'h0010, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 15'h0010, 8'h10));
    tbl.push_back(mk(16'h0010, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 16'h5A5A, 0, 0, 15'h0010, 8'h10));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'h5A5A, 0, 0, 15'h0010, 8'h10));
    tbl.push_back(mk(16'h8004, 16'h1234, 1, 0, 0, 16'h0000, 1, 0, 16'h5A5A, 1, 0, 15'h0004, 8'h04));
    tbl.push_back(mk(16'h8004, 16'h1234, 1, 0, 0, 16'h0000, 1, 0, 16'h5A5A, 0, 0, 15'h0004, 8'h04));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'h5A5A, 0, 0, 15'h0004, 8'h04));
    tbl.push_back(mk(16'h8004, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 16'h5A5A, 0, 0, 15'h0004, 8'h04));
    tbl.push_back(mk(16'h8004, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 16'h1234, 0, 0, 15'h0004, 8'h04));
    tbl.push_back(mk(16'h8004, 16'hCAFE, 1, 0, 0, 16'h0000, 1, 0, 16'h1234, 1, 0, 15'h0004, 8'h04));
    tbl.push_back(mk(16'h8004, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 16'h1234, 0, 0, 15'h0004, 8'h04));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'hCAFE, 0, 0, 15'h0004, 8'h04));
    tbl.push_back(mk(16'hFF03, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 16'hCAFE, 0, 0, 15'h7F03, 8'h03));
    tbl.push_back(mk(16'hFF03, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 16'hCAFE, 0, 1, 15'h7F03, 8'h03));
    tbl.push_back(mk(16'hFF03, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 16'hCAFE, 0, 1, 15'h7F03, 8'h03));
    tbl.push_back(mk(16'hFF03, 16'h0000, 0, 1, 1, 16'hBEEF, 0, 0, 16'hCAFE, 0, 1, 15'h7F03, 8'h03));
    tbl.push_back(mk(16'hFF03, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 16'hBEEF, 0, 0, 15'h7F03, 8'h03));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'hBEEF, 0, 0, 15'h7F03, 8'h03));
    tbl.push_back(mk(16'h8008, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'hBEEF, 0, 0, 15'h0008, 8'h08));
    tbl.push_back(mk(16'h8008, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'hBEEF, 0, 0, 15'h0008, 8'h08));
    tbl.push_back(mk(16'h8008, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'hBEEF, 0, 0, 15'h0008, 8'h08));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'hBEEF, 0, 0, 15'h0008, 8'h08));
    tbl.push_back(mk(16'h0100, 16'h7777, 1, 0, 0, 16'h0000, 0, 0, 16'hBEEF, 0, 0, 15'h0100, 8'h00));
    tbl.push_back(mk(16'h0100, 16'h7777, 1, 0, 0, 16'h0000, 1, 1, 16'hBEEF, 0, 0, 15'h0100, 8'h00));
    tbl.push_back(mk(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'hBEEF, 0, 0, 15'h0100, 8'h00));

    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      cyc(tbl[i].a, tbl[i].wd, tbl[i].r, tbl[i].w, tbl[i].ak, tbl[i].id, 1'b0);
      chk($sformatf("v%0d ready", i), 16'(ready1), 16'(tbl[i].erdy));
      chk($sformatf("v%0d bus_error", i), 16'(berr1), 16'(tbl[i].eber));
      chk($sformatf("v%0d cpu_rdata", i), rdata1, tbl[i].erd);
      chk($sformatf("v%0d ram_we", i), 16'(ram_we1), 16'(tbl[i].ewe));
      chk($sformatf("v%0d io_rd", i), 16'(io_rd1), 16'(tbl[i].eiord));
      chk($sformatf("v%0d io_wr", i), 16'(io_wr1), 16'h0000);
      chk($sformatf("v%0d ram_addr", i), 16'(ram_addr1), 16'(tbl[i].era));
      chk($sformatf("v%0d rom_addr", i), 16'(rom_addr1), 16'(tbl[i].era));
      chk($sformatf("v%0d io_addr", i), 16'(io_addr1), 16'(tbl[i].eio));
    end

    // I/O write with no ack: 15 strobe cycles, then error and release.
    cyc(16'hFF10, 16'h0042, 1, 0, 0, 16'h0000, 0);
    chk("tmo req ready", 16'(ready1), 16'h0000);
    for (int k = 1; k <= 15; k++) begin
      cyc(16'hFF10, 16'h0042, 1, 0, 0, 16'h0000, 0);
      chk($sformatf("tmo c%0d io_wr", k), 16'(io_wr1), 16'h0001);
      chk($sformatf("tmo c%0d ready", k), 16'(ready1), 16'h0000);
      chk($sformatf("tmo c%0d bus_error", k), 16'(berr1), 16'h0000);
      chk($sformatf("tmo c%0d io_wdata", k), io_wdata1, 16'h0042);
    end
    cyc(16'hFF10, 16'h0042, 1, 0, 0, 16'h0000, 0);
    chk("tmo end bus_error", 16'(berr1), 16'h0001);
    chk("tmo end io_wr", 16'(io_wr1), 16'h0000);
    chk("tmo end ready", 16'(ready1), 16'h0000 | 16'(1'b1));
    cyc(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 0);
    chk("tmo after bus_error", 16'(berr1), 16'h0000);

    // Second instance from a clean reset.
    cyc(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1);
    cyc(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1);

    // RAM write with 3 wait cycles.
    for (int k = 0; k < 3; k++) begin
      cyc(16'h8002, 16'h5555, 1, 0, 0, 16'h0000, 0);
      chk($sformatf("w3 c%0d ready", k), 16'(ready3), 16'h0000);
      chk($sformatf("w3 c%0d ram_we", k), 16'(ram_we3), (k == 2) ? 16'h0001 : 16'h0000);
    end
    chk("w3 ram_addr", 16'(ram_addr3), 16'h0002);
    chk("w3 rom_addr", 16'(rom_addr3), 16'h0002);
    chk("w3 ram_wdata", ram_wdata3, 16'h5555);
    chk("w3 io_wdata", io_wdata3, 16'h5555);
    cyc(16'h8002, 16'h5555, 1, 0, 0, 16'h0000, 0);
    chk("w3 done ready", 16'(ready3), 16'h0001);
    chk("w3 done ram_we", 16'(ram_we3), 16'h0000);
    cyc(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 0);

    // RAM read with 3 wait cycles.
    ram_rdata3 = 16'h3C3C;
    for (int k = 0; k < 3; k++) begin
      cyc(16'h8002, 16'h0000, 0, 1, 0, 16'h0000, 0);
      chk($sformatf("r3 c%0d ready", k), 16'(ready3), 16'h0000);
    end
    cyc(16'h8002, 16'h0000, 0, 1, 0, 16'h0000, 0);
    chk("r3 done ready", 16'(ready3), 16'h0001);
    chk("r3 done cpu_rdata", rdata3, 16'h3C3C);
    cyc(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 0);

    // Reset in the last wait cycle of a RAM write aborts it.
    begin
      int snap;
      snap = we3_cnt;
      cyc(16'h8006, 16'h9999, 1, 0, 0, 16'h0000, 0);
      cyc(16'h8006, 16'h9999, 1, 0, 0, 16'h0000, 0);
      cyc(16'h8006, 16'h9999, 1, 0, 0, 16'h0000, 1);
      chk("rst ram_we during reset", 16'(ram_we3), 16'h0000);
      cyc(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 0);
      chk("rst ready", 16'(ready3), 16'h0001);
      chk("rst ram_we", 16'(ram_we3), 16'h0000);
      chk("rst cpu_rdata", rdata3, 16'h0000);
      chk("rst write count", 16'(we3_cnt - snap), 16'h0000);
    end

    // I/O read acknowledged in the first strobe cycle.
    cyc(16'hFF05, 16'h0000, 0, 1, 0, 16'h0000, 0);
    chk("ack1 req ready", 16'(ready3), 16'h0000);
    cyc(16'hFF05, 16'h0000, 0, 1, 1, 16'h1111, 0);
    chk("ack1 io_rd", 16'(io_rd3), 16'h0001);
    chk("ack1 io_wr", 16'(io_wr3), 16'h0000);
    chk("ack1 io_addr", 16'(io_addr3), 16'h0005);
    chk("ack1 ready", 16'(ready3), 16'h0000);
    cyc(16'hFF05, 16'h0000, 0, 1, 0, 16'h0000, 0);
    chk("ack1 done ready", 16'(ready3), 16'h0001);
    chk("ack1 cpu_rdata", rdata3, 16'h1111);
    chk("ack1 bus_error", 16'(berr3), 16'h0000);
    chk("ack1 io_rd drop", 16'(io_rd3), 16'h0000);
    cyc(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 0);

    // Ack arriving in the timeout cycle wins.
    cyc(16'hFF06, 16'h0000, 0, 1, 0, 16'h0000, 0);
    chk("tie req ready", 16'(ready3), 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      cyc(16'hFF06, 16'h0000, 0, 1, 0, 16'h0000, 0);
      chk($sformatf("tie c%0d io_rd", k), 16'(io_rd3), 16'h0001);
      chk($sformatf("tie c%0d bus_error", k), 16'(berr3), 16'h0000);
    end
    cyc(16'hFF06, 16'h0000, 0, 1, 1, 16'h2222, 0);
    chk("tie ack ready", 16'(ready3), 16'h0000);
    cyc(16'hFF06, 16'h0000, 0, 1, 0, 16'h0000, 0);
    chk("tie done ready", 16'(ready3), 16'h0001);
    chk("tie bus_error", 16'(berr3), 16'h0000);
    chk("tie cpu_rdata", rdata3, 16'h2222);
    cyc(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tiny16_memctl.md
# tiny16_memctl

Memory/bus controller sitting directly downstream of the tiny16 CPU bus. Decodes the CPU address into ROM, RAM and I/O regions, inserts per-region wait states by holding `ready` low, drives the selected target, and returns read data on the CPU's input bus. Also flags illegal accesses (ROM write, simultaneous rd/wr, I/O timeout) on `bus_error`.

## Interface

- `ROM_WAIT`, default 1: extra cycles for a ROM access (0–15).
- `RAM_WAIT`, default 0: extra cycles for a RAM access (0–15).
- `IO_TIMEOUT`, default 15: max cycles waiting for `io_ack` before error (1–255).

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `address`  in  16  CPU address.
- `cpu_wdata`  in  16  CPU write data (CPU `data_out`).
- `cpu_rdata`  out  16  read data to CPU (CPU `data_in`).
- `rd`  in  1  active-low read strobe.
- `wr`  in  1  active-low write strobe.
- `ready`  out  1  high = access complete / bus idle; low = CPU must stall.
- `bus_error`  out  1  one-cycle pulse on illegal access.
- `rom_addr`  out  15  ROM word address.
- `rom_data`  in  16  ROM read data, valid `ROM_WAIT` cycles after address.
- `ram_addr`  out  15  RAM word address (`address[14:0]`).
- `ram_wdata`  out  16  RAM write data.
- `ram_rdata`  in  16  RAM read data.
- `ram_we`  out  1  active-high one-cycle RAM write enable.
- `io_addr`  out  8  I/O register index.
- `io_wdata`  out  16  I/O write data.
- `io_rdata`  in  16  I/O read data, valid with `io_ack`.
- `io_rd`, `io_wr`  out  1 each  active-high I/O strobes, held until ack/timeout.
- `io_ack`  in  1  I/O target completion.

## Operation

- Decode: `0x0000–0x7FFF` ROM; `0x8000–0xFEFF` RAM; `0xFF00–0xFFFF` I/O (`io_addr = address[7:0]`).
- Request present when `rd==0` xor `wr==0`. Both low: illegal, `bus_error` pulse, no target access, `ready` high.
- States: IDLE, WAIT, IO, DONE.
  - IDLE: on request latch region, direction, address, wdata. ROM/RAM with wait 0 → complete in same cycle (ready stays high, data captured at this edge). Wait > 0 → load counter = wait, go WAIT. I/O → go IO.
  - WAIT: decrement counter; at 1 capture data (read) or pulse `ram_we` (write), go DONE.
  - IO: assert `io_rd`/`io_wr`; on `io_ack` capture `io_rdata`, go DONE; timeout counter reaching `IO_TIMEOUT` → `bus_error` pulse, `cpu_rdata = 0xFFFF`, go DONE.
  - DONE: `ready` high; return to IDLE when `rd` and `wr` both high, or immediately accept a new request if the strobe changed (different address or direction).
- `ready` = 0 in WAIT and IO, and combinationally 0 in IDLE the cycle a request with nonzero latency arrives; 1 otherwise.
- ROM write: no target access, `bus_error` pulse, completes with ROM timing.
- RAM zero-wait write: `ram_we` pulsed for exactly one cycle per request.
- `cpu_rdata` held from last completed read until next read completes.
- Address/strobe changes during WAIT/IO are ignored (latched values used).

## Timing

- Reset values: `ready=1`, `bus_error=0`, `cpu_rdata=0`, `ram_we=0`, `io_rd=0`, `io_wr=0`, all address/wdata outputs 0, state IDLE, counters 0.
- Reset mid-access aborts immediately: strobes drop next edge, no write completes, `ready=1`.
- ROM/RAM latency: wait N → `ready` low exactly N cycles, data valid on `cpu_rdata` the cycle `ready` returns high.
- I/O latency: `ready` low from request until one cycle after `io_ack` is sampled (or timeout).
- `io_ack` asserted in the same cycle strobes first rise is accepted.
- Timeout and `io_ack` in same cycle: ack wins, no error.

## Test plan

- Reset then ROM read `0x0010` with ROM_WAIT=1, rom_data=0x5A5A → ready low 1 cycle, cpu_rdata=0x5A5A.
- RAM write `0x8004` data 0x1234 then read back, RAM_WAIT=0 → ram_we one pulse, ram_addr=0x0004, ready never low, readback 0x1234.
- I/O read `0xFF03`, io_ack after 3 cycles with 0xBEEF → io_addr=0x03, ready low 4 cycles, cpu_rdata=0xBEEF.
- I/O write with no ack, IO_TIMEOUT=15 → bus_error pulse after 15 cycles, io_wr drops, ready high.
- ROM write `0x0100`, and rd/wr both low → bus_error pulse each, ram_we/io_wr never asserted.
- Assert reset during RAM write wait (RAM_WAIT=3, cycle 2) → ram_we never pulses, ready=1 next cycle.
